// File: rtl/gvt_tracker.sv
// gvt_tracker: Global Virtual Time for the PHOLD PDES engine.
// Each round takes the minimum of the active cores' LVTs and the queue head time.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   sim_end         simulation end time (static while running)
//   core_lvt_vld    per-core LVT update strobes
//   core_lvt        packed per-core LVTs, core i at [i*TIME_W +: TIME_W]
//   core_active     per-core busy flags
//   queue_empty     event queue holds nothing
//   queue_min_time  queue head timestamp (valid when !queue_empty)
//   gvt             current GVT, never decreases
//   gvt_upd         one-cycle pulse when gvt changes
//   rtn_vld         simulation finished, sticky until reset
//   gvt_err         sticky monotonicity error (GVT_MONO_CHECK_EN only)
// Build option: define GVT_MONO_CHECK_EN to add the gvt_err checker output.
module gvt_tracker #(
   parameter int NUM_CORES = 8,
   parameter int TIME_W    = 16,
   parameter int CORE_W    = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [TIME_W-1:0]           sim_end,
   input  logic [NUM_CORES-1:0]        core_lvt_vld,
   input  logic [NUM_CORES*TIME_W-1:0] core_lvt,
   input  logic [NUM_CORES-1:0]        core_active,
   input  logic                        queue_empty,
   input  logic [TIME_W-1:0]           queue_min_time,
   output logic [TIME_W-1:0]           gvt,
   output logic                        gvt_upd,
   output logic                        rtn_vld
`ifdef GVT_MONO_CHECK_EN
   ,
   output logic                        gvt_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_COMMIT,
      S_DONE
   } state_t;

   // All-ones is "infinite": an empty queue seeds the scan with it
   localparam logic [TIME_W-1:0] INF  = '1;
   localparam logic [CORE_W-1:0] LAST = CORE_W'(NUM_CORES - 1);

   state_t            state;
   logic [TIME_W-1:0] lvt_r [NUM_CORES];
   logic [TIME_W-1:0] min_r;
   logic [CORE_W-1:0] idx;

   logic [TIME_W-1:0] seed;
   logic [TIME_W-1:0] lvt_sel;
   logic [TIME_W-1:0] gvt_nxt;
   logic              idle_all;
   logic              adv;

   assign seed     = queue_empty ? INF : queue_min_time;
   assign lvt_sel  = lvt_r[idx];
   assign idle_all = (core_active == '0) && queue_empty;

   // Only a strictly larger, finite minimum moves gvt forward
   assign adv     = !idle_all && (min_r > gvt) && (min_r != INF);
   assign gvt_nxt = adv ? min_r : gvt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CORES; i++)
            lvt_r[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CORES; i++)
            if (core_lvt_vld[i])
               lvt_r[i] <= core_lvt[i*TIME_W +: TIME_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         min_r   <= '0;
         gvt     <= '0;
         gvt_upd <= 1'b0;
         rtn_vld <= 1'b0;
      end else begin
         gvt_upd <= 1'b0;
         unique case (state)
            S_IDLE: begin
               idx   <= '0;
               min_r <= seed;
               state <= S_SCAN;
            end
            S_SCAN: begin
               // Registered LVT: a same-cycle write lands next round
               if (core_active[idx] && (lvt_sel < min_r))
                  min_r <= lvt_sel;
               if (idx == LAST)
                  state <= S_COMMIT;
               else
                  idx <= idx + 1'b1;
            end
            S_COMMIT: begin
               if (adv) begin
                  gvt     <= min_r;
                  gvt_upd <= 1'b1;
               end
               if (idle_all || (gvt_nxt >= sim_end)) begin
                  state   <= S_DONE;
                  rtn_vld <= 1'b1;
               end else begin
                  state <= S_SCAN;
                  idx   <= '0;
                  min_r <= seed;
               end
            end
            S_DONE: begin
               rtn_vld <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef GVT_MONO_CHECK_EN
   // Sticky flag: some active source reported a time behind committed gvt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         gvt_err <= 1'b0;
      else if ((state == S_COMMIT) && !idle_all && (min_r < gvt))
         gvt_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_gvt_tracker.sv
// tb_gvt_tracker: directed vectors and round sequences for gvt_tracker.
// One round from reset = 1 IDLE + 8 SCAN + 1 COMMIT cycle.
module tb_gvt_tracker;

   localparam int N = 8;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   sim_end;
   logic [N-1:0]   core_lvt_vld;
   logic [N*W-1:0] core_lvt;
   logic [N-1:0]   core_active;
   logic           queue_empty;
   logic [W-1:0]   queue_min_time;
   logic [W-1:0]   gvt;
   logic           gvt_upd;
   logic           rtn_vld;
`ifdef GVT_MONO_CHECK_EN
   logic           gvt_err;
`endif

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   gvt_tracker #(
      .NUM_CORES(N),
      .TIME_W(W),
      .CORE_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sim_end(sim_end),
      .core_lvt_vld(core_lvt_vld),
      .core_lvt(core_lvt),
      .core_active(core_active),
      .queue_empty(queue_empty),
      .queue_min_time(queue_min_time),
      .gvt(gvt),
      .gvt_upd(gvt_upd),
      .rtn_vld(rtn_vld)
`ifdef GVT_MONO_CHECK_EN
      ,
      .gvt_err(gvt_err)
`endif
   );

   typedef struct {
      logic [7:0]   act;
      logic [127:0] lvt;
      logic         qe;
      logic [15:0]  qmin;
      logic [15:0]  send;
      logic [15:0]  egvt;
      logic         eupd;
      logic         ertn;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [127:0] lv8(
      input logic [15:0] a0, input logic [15:0] a1,
      input logic [15:0] a2, input logic [15:0] a3,
      input logic [15:0] a4, input logic [15:0] a5,
      input logic [15:0] a6, input logic [15:0] a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset(input logic [15:0] send);
      rst_n        = 1'b0;
      core_lvt_vld = '0;
      sim_end      = send;
      step(2);
      chk("rst_gvt", 32'(gvt), 32'd0);
      chk("rst_upd", 32'(gvt_upd), 32'd0);
      chk("rst_rtn", 32'(rtn_vld), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b0;
      sim_end        = '0;
      core_lvt_vld   = '0;
      core_lvt       = '0;
      core_active    = '0;
      queue_empty    = 1'b1;
      queue_min_time = '0;

      vecs[0]  = '{8'h00, lv8(3,3,3,3,3,3,3,3), 1'b1, 16'd0,
                   16'd100, 16'd0, 1'b0, 1'b1};
      vecs[1]  = '{8'h0F, lv8(5,9,7,12,1,1,1,1), 1'b0, 16'd20,
                   16'd100, 16'd5, 1'b1, 1'b0};
      vecs[2]  = '{8'h00, lv8(1,1,1,1,1,1,1,1), 1'b0, 16'd40,
                   16'd100, 16'd40, 1'b1, 1'b0};
      vecs[3]  = '{8'h01, lv8(0,9,9,9,9,9,9,9), 1'b1, 16'd0,
                   16'd0, 16'd0, 1'b0, 1'b1};
      vecs[4]  = '{8'h10, lv8(1,1,1,1,5,1,1,1), 1'b1, 16'd0,
                   16'd0, 16'd5, 1'b1, 1'b1};
      vecs[5]  = '{8'h80, lv8(2,2,2,2,2,2,2,16'hFFFF), 1'b1, 16'd0,
                   16'd100, 16'd0, 1'b0, 1'b0};
      vecs[6]  = '{8'h40, lv8(1,1,1,1,1,2,60,1), 1'b0, 16'd70,
                   16'd100, 16'd60, 1'b1, 1'b0};
      vecs[7]  = '{8'h08, lv8(1,1,1,16'hFFFE,1,1,1,1), 1'b1, 16'd0,
                   16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
      vecs[8]  = '{8'h80, lv8(1,1,1,1,1,1,1,100), 1'b1, 16'd0,
                   16'd100, 16'd100, 1'b1, 1'b1};
      vecs[9]  = '{8'h02, lv8(1,50,1,1,1,1,1,1), 1'b0, 16'd30,
                   16'd100, 16'd30, 1'b1, 1'b0};
      vecs[10] = '{8'hFF, lv8(80,71,62,53,44,35,26,17), 1'b0, 16'd90,
                   16'd100, 16'd17, 1'b1, 1'b0};

      for (int i = 0; i < 11; i++) begin
         do_reset(vecs[i].send);
         core_active    = vecs[i].act;
         queue_empty    = vecs[i].qe;
         queue_min_time = vecs[i].qmin;
         core_lvt       = vecs[i].lvt;
         core_lvt_vld   = '1;
         step(1);
         core_lvt_vld = '0;
         step(9);
         chk($sformatf("v%0d_gvt", i), 32'(gvt), 32'(vecs[i].egvt));
         chk($sformatf("v%0d_upd", i), 32'(gvt_upd), 32'(vecs[i].eupd));
         chk($sformatf("v%0d_rtn", i), 32'(rtn_vld), 32'(vecs[i].ertn));
         step(1);
         chk($sformatf("v%0d_upd_drop", i), 32'(gvt_upd), 32'd0);
         chk($sformatf("v%0d_rtn_hold", i), 32'(rtn_vld),
             32'(vecs[i].ertn));
      end

      // Rising GVT over several rounds, finishing past sim_end
      do_reset(16'd100);
      core_active    = 8'h0F;
      queue_empty    = 1'b0;
      queue_min_time = 16'd20;
      core_lvt       = lv8(5,9,7,12,0,0,0,0);
      core_lvt_vld   = '1;
      step(1);
      core_lvt_vld = '0;
      step(9);
      chk("a_gvt5", 32'(gvt), 32'd5);
      chk("a_upd5", 32'(gvt_upd), 32'd1);
      chk("a_rtn5", 32'(rtn_vld), 32'd0);
      core_lvt[0*W +: W] = 16'd30;
      core_lvt[2*W +: W] = 16'd101;
      core_lvt_vld       = 8'b0000_0101;
      core_active        = 8'b0000_0101;
      queue_min_time     = 16'd150;
      step(1);
      core_lvt_vld = '0;
      step(8);
      chk("a_late_gvt", 32'(gvt), 32'd5);
      chk("a_late_upd", 32'(gvt_upd), 32'd0);
      step(9);
      chk("a_gvt30", 32'(gvt), 32'd30);
      chk("a_upd30", 32'(gvt_upd), 32'd1);
      chk("a_rtn30", 32'(rtn_vld), 32'd0);
      core_lvt[0*W +: W] = 16'd110;
      core_lvt_vld       = 8'b0000_0001;
      step(1);
      core_lvt_vld = '0;
      step(8);
      chk("a_hold_gvt", 32'(gvt), 32'd30);
      chk("a_hold_upd", 32'(gvt_upd), 32'd0);
      step(9);
      chk("a_gvt101", 32'(gvt), 32'd101);
      chk("a_upd101", 32'(gvt_upd), 32'd1);
      chk("a_rtn101", 32'(rtn_vld), 32'd1);
      core_lvt[0*W +: W] = 16'd200;
      core_lvt_vld       = 8'b0000_0001;
      queue_min_time     = 16'd300;
      step(1);
      core_lvt_vld = '0;
      step(20);
      chk("a_done_gvt", 32'(gvt), 32'd101);
      chk("a_done_upd", 32'(gvt_upd), 32'd0);
      chk("a_done_rtn", 32'(rtn_vld), 32'd1);

      // A late LVT below gvt must not pull gvt back
      do_reset(16'd100);
      core_active        = 8'h01;
      queue_empty        = 1'b1;
      core_lvt           = '0;
      core_lvt[0*W +: W] = 16'd30;
      core_lvt_vld       = 8'h01;
      step(1);
      core_lvt_vld = '0;
      step(9);
      chk("b_gvt30", 32'(gvt), 32'd30);
      chk("b_upd30", 32'(gvt_upd), 32'd1);
      core_lvt[0*W +: W] = 16'd10;
      core_lvt_vld       = 8'h01;
      step(1);
      core_lvt_vld = '0;
      step(8);
      chk("b_r1_gvt", 32'(gvt), 32'd30);
      chk("b_r1_upd", 32'(gvt_upd), 32'd0);
`ifdef GVT_MONO_CHECK_EN
      chk("b_r1_err", 32'(gvt_err), 32'd0);
`endif
      step(9);
      chk("b_low_gvt", 32'(gvt), 32'd30);
      chk("b_low_upd", 32'(gvt_upd), 32'd0);
      chk("b_low_rtn", 32'(rtn_vld), 32'd0);
`ifdef GVT_MONO_CHECK_EN
      chk("b_low_err", 32'(gvt_err), 32'd1);
`endif

      // Asynchronous reset in the middle of a scan
      step(3);
      rst_n = 1'b0;
      #1;
      chk("c_async_gvt", 32'(gvt), 32'd0);
      chk("c_async_rtn", 32'(rtn_vld), 32'd0);
      chk("c_async_upd", 32'(gvt_upd), 32'd0);
`ifdef GVT_MONO_CHECK_EN
      chk("c_async_err", 32'(gvt_err), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n              = 1'b1;
      core_lvt[0*W +: W] = 16'd40;
      core_lvt_vld       = 8'h01;
      step(1);
      core_lvt_vld = '0;
      step(9);
      chk("c_fresh_gvt", 32'(gvt), 32'd40);
      chk("c_fresh_upd", 32'(gvt_upd), 32'd1);
      chk("c_fresh_rtn", 32'(rtn_vld), 32'd0);

      // LVT write to core 2 on the very cycle core 2 is scanned
      do_reset(16'd100);
      core_active        = 8'h04;
      queue_empty        = 1'b0;
      queue_min_time     = 16'd50;
      core_lvt           = '0;
      core_lvt[2*W +: W] = 16'd8;
      core_lvt_vld       = 8'h04;
      step(1);
      core_lvt_vld = '0;
      step(2);
      core_lvt[2*W +: W] = 16'd3;
      core_lvt_vld       = 8'h04;
      step(1);
      core_lvt_vld = '0;
      step(6);
      chk("d_gvt8", 32'(gvt), 32'd8);
      chk("d_upd8", 32'(gvt_upd), 32'd1);
      chk("d_rtn8", 32'(rtn_vld), 32'd0);
      step(9);
      chk("d_next_gvt", 32'(gvt), 32'd8);
      chk("d_next_upd", 32'(gvt_upd), 32'd0);
`ifdef GVT_MONO_CHECK_EN
      chk("d_next_err", 32'(gvt_err), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
